// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite signal bundle between the bus side (master modport) and the SRAM slave.
interface ahb_sram_slave_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY_IN;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY_IN,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY_IN,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: pipelined address/data phases, wait states, byte lanes, write-to-read forwarding.
// Define AHB_SRAM_ERR_EN to return a two-cycle ERROR for out-of-range, misaligned or oversize transfers.
module ahb_sram_slave #(
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic            HCLK,
    input  logic            HRESET,
    ahb_sram_slave_if.slave bus
);
    localparam int         WORDS      = MEM_BYTES / 4;
    localparam int         AW         = $clog2(MEM_BYTES);
    localparam int         IW         = AW - 2;
    localparam logic [3:0] WS         = 4'(WAIT_STATES);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

    state_t         state;
    logic [3:0]     cnt;
    logic           wr_q;
    logic [3:0]     be_q;
    logic [IW-1:0]  idx_q;
    logic           ready_q;
    logic [1:0]     resp_q;
    logic [31:0]    rdata_q;
    logic [31:0]    mem [WORDS];

    logic           accept;
    logic           err_a;
    logic           commit;
    logic [3:0]     be_a;
    logic [IW-1:0]  idx_a;
    logic [IW-1:0]  rd_idx;
    logic [31:0]    rd_word;
    logic           unused_bits;

    assign accept = bus.HSEL & bus.HREADY_IN & bus.HTRANS[1];
    assign idx_a  = bus.HADDR[AW-1:2];
    assign commit = (state == S_DONE) && wr_q;

    // Only the WAIT->DONE load reads the latched index; every other load is a fresh accept.
    assign rd_idx = (state == S_WAIT) ? idx_q : idx_a;

`ifdef AHB_SRAM_ERR_EN
    assign err_a = (|bus.HADDR[31:AW])
                 || (bus.HSIZE == 3'b001 && bus.HADDR[0])
                 || (bus.HSIZE == 3'b010 && bus.HADDR[1:0] != 2'b00)
                 || (bus.HSIZE > 3'b010);
`else
    assign err_a = 1'b0;
`endif

    assign unused_bits = ^{bus.HADDR[31:AW], bus.HTRANS[0]};

    always_comb begin
        // NOTE: every always_comb output is given a default first so no path can infer a latch.
        be_a = 4'b1111;
        case (bus.HSIZE)
            3'b000:  be_a = 4'b0001 << bus.HADDR[1:0];
            3'b001:  be_a = bus.HADDR[1] ? 4'b1100 : 4'b0011;
            default: be_a = 4'b1111;
        endcase
    end

    // A read accepted on the edge that commits a write to the same word sees the new lanes.
    always_comb begin
        rd_word = mem[rd_idx];
        for (int b = 0; b < 4; b++) begin
            if (commit && (idx_q == rd_idx) && be_q[b]) begin
                rd_word[8*b +: 8] = bus.HWDATA[8*b +: 8];
            end
        end
    end

    // NOTE: the array has no reset; contents survive HRESET and the array can still map onto RAM.
    always_ff @(posedge HCLK) begin
        if (!HRESET && commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= bus.HWDATA[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            be_q    <= 4'b0000;
            idx_q   <= '0;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
            rdata_q <= 32'h0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (cnt == 4'd1) begin
                        state   <= S_DONE;
                        cnt     <= 4'd0;
                        ready_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= rd_word;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= RESP_ERROR;
                end
                default: begin
                    // IDLE, DONE and ERR2 all drive HREADY=1, so a new address phase may be taken.
                    if (accept) begin
                        idx_q <= idx_a;
                        be_q  <= be_a;
                        wr_q  <= bus.HWRITE && !err_a;
                        if (err_a) begin
                            state   <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= RESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state   <= S_DONE;
                            ready_q <= 1'b1;
                            resp_q  <= RESP_OKAY;
                            if (!bus.HWRITE) begin
                                rdata_q <= rd_word;
                            end
                        end else begin
                            state   <= S_WAIT;
                            cnt     <= WS;
                            ready_q <= 1'b0;
                            resp_q  <= RESP_OKAY;
                        end
                    end else begin
                        state   <= S_IDLE;
                        wr_q    <= 1'b0;
                        ready_q <= 1'b1;
                        resp_q  <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign bus.HRDATA = rdata_q;
    assign bus.HREADY = ready_q;
    assign bus.HRESP  = resp_q;
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one slave with zero wait states (index 0) and one with two wait states (index 1).
module tb_ahb_sram_slave;
    logic HCLK;
    logic HRESET;

    int n_tests = 0;
    int n_fail  = 0;

    logic        t_sel    [2];
    logic [1:0]  t_trans  [2];
    logic        t_write  [2];
    logic [2:0]  t_size   [2];
    logic [31:0] t_addr   [2];
    logic [31:0] t_wdata  [2];
    logic        t_hin_en [2];
    logic [31:0] o_rdata  [2];
    logic        o_ready  [2];
    logic [1:0]  o_resp   [2];

    ahb_sram_slave_if bus0();
    ahb_sram_slave_if bus2();

    assign bus0.HSEL      = t_sel[0];
    assign bus0.HTRANS    = t_trans[0];
    assign bus0.HWRITE    = t_write[0];
    assign bus0.HSIZE     = t_size[0];
    assign bus0.HADDR     = t_addr[0];
    assign bus0.HWDATA    = t_wdata[0];
    assign bus0.HREADY_IN = bus0.HREADY & t_hin_en[0];
    assign o_rdata[0]     = bus0.HRDATA;
    assign o_ready[0]     = bus0.HREADY;
    assign o_resp[0]      = bus0.HRESP;

    assign bus2.HSEL      = t_sel[1];
    assign bus2.HTRANS    = t_trans[1];
    assign bus2.HWRITE    = t_write[1];
    assign bus2.HSIZE     = t_size[1];
    assign bus2.HADDR     = t_addr[1];
    assign bus2.HWDATA    = t_wdata[1];
    assign bus2.HREADY_IN = bus2.HREADY & t_hin_en[1];
    assign o_rdata[1]     = bus2.HRDATA;
    assign o_ready[1]     = bus2.HREADY;
    assign o_resp[1]      = bus2.HRESP;

    ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(0)) u_ws0 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus0)
    );

    ahb_sram_slave #(.MEM_BYTES(1024), .WAIT_STATES(2)) u_ws2 (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus2)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "bench timed out");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Entered at a falling edge with the slave ready; returns after the data phase has ended.
    task automatic xfer(input int b, input logic wr, input logic [2:0] size,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int waits, output logic [1:0] resp_w,
                        output logic [1:0] resp_d, output logic [31:0] rdata);
        t_sel[b]   = 1'b1;
        t_trans[b] = 2'b10;
        t_write[b] = wr;
        t_size[b]  = size;
        t_addr[b]  = addr;
        @(negedge HCLK);
        t_sel[b]   = 1'b0;
        t_trans[b] = 2'b00;
        t_wdata[b] = wdata;
        waits  = 0;
        resp_w = 2'b00;
        while (o_ready[b] !== 1'b1 && waits < 20) begin
            resp_w = o_resp[b];
            waits++;
            @(negedge HCLK);
        end
        resp_d = o_resp[b];
        rdata  = o_rdata[b];
        @(negedge HCLK);
    endtask

    initial begin
        int          w;
        logic [1:0]  rw;
        logic [1:0]  rd;
        logic [31:0] rdat;

        for (int i = 0; i < 2; i++) begin
            t_sel[i]    = 1'b0;
            t_trans[i]  = 2'b00;
            t_write[i]  = 1'b0;
            t_size[i]   = 3'b010;
            t_addr[i]   = 32'h0;
            t_wdata[i]  = 32'h0;
            t_hin_en[i] = 1'b1;
        end
        HRESET = 1'b1;
        @(negedge HCLK);
        @(negedge HCLK);

        // Reset state on both slaves
        check("rst_ready0", 32'(o_ready[0]), 32'd1);
        check("rst_resp0",  32'(o_resp[0]),  32'd0);
        check("rst_rdata0", o_rdata[0],      32'h0);
        check("rst_ready2", 32'(o_ready[1]), 32'd1);
        check("rst_resp2",  32'(o_resp[1]),  32'd0);
        check("rst_rdata2", o_rdata[1],      32'h0);
        HRESET = 1'b0;
        @(negedge HCLK);

        // Two-wait-state slave: seed 0x10 and read it back so HRDATA is non-zero
        xfer(1, 1'b1, 3'b010, 32'h10, 32'h5555_5555, w, rw, rd, rdat);
        check("ws2_wr10_waits", 32'(w), 32'd2);
        xfer(1, 1'b0, 3'b010, 32'h10, 32'h0, w, rw, rd, rdat);
        check("ws2_rd10_waits", 32'(w), 32'd2);
        check("ws2_rd10_data", rdat, 32'h5555_5555);

        // Reset during WAIT of a write to 0x10
        t_sel[1]   = 1'b1;
        t_trans[1] = 2'b10;
        t_write[1] = 1'b1;
        t_size[1]  = 3'b010;
        t_addr[1]  = 32'h10;
        @(negedge HCLK);
        check("midrst_in_wait", 32'(o_ready[1]), 32'd0);
        t_sel[1]   = 1'b0;
        t_trans[1] = 2'b00;
        t_wdata[1] = 32'h1234_5678;
        HRESET     = 1'b1;
        @(negedge HCLK);
        check("midrst_ready", 32'(o_ready[1]), 32'd1);
        check("midrst_resp",  32'(o_resp[1]),  32'd0);
        check("midrst_rdata", o_rdata[1],      32'h0);
        @(negedge HCLK);
        HRESET = 1'b0;
        @(negedge HCLK);
        xfer(1, 1'b0, 3'b010, 32'h10, 32'h0, w, rw, rd, rdat);
        check("midrst_no_write", rdat, 32'h5555_5555);

        // Wait-state write then read at 0x20
        xfer(1, 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, w, rw, rd, rdat);
        check("ws2_wr20_waits", 32'(w), 32'd2);
        check("ws2_wr20_resp",  32'(rd), 32'd0);
        xfer(1, 1'b0, 3'b010, 32'h20, 32'h0, w, rw, rd, rdat);
        check("ws2_rd20_waits", 32'(w), 32'd2);
        check("ws2_rd20_data",  rdat, 32'hDEAD_BEEF);

        // Zero-wait slave: byte write 0x41 followed back-to-back by word read 0x40
        xfer(0, 1'b1, 3'b010, 32'h40, 32'h1122_3344, w, rw, rd, rdat);
        check("ws0_wr40_waits", 32'(w), 32'd0);
        t_sel[0]   = 1'b1;
        t_trans[0] = 2'b10;
        t_write[0] = 1'b1;
        t_size[0]  = 3'b000;
        t_addr[0]  = 32'h41;
        @(negedge HCLK);
        check("b2b_wr_ready", 32'(o_ready[0]), 32'd1);
        t_trans[0] = 2'b11;
        t_write[0] = 1'b0;
        t_size[0]  = 3'b010;
        t_addr[0]  = 32'h40;
        t_wdata[0] = 32'hABAB_ABAB;
        @(negedge HCLK);
        check("fwd_ready", 32'(o_ready[0]), 32'd1);
        check("fwd_rdata", o_rdata[0], 32'h1122_AB44);
        t_sel[0]   = 1'b0;
        t_trans[0] = 2'b00;
        @(negedge HCLK);
        xfer(0, 1'b0, 3'b010, 32'h40, 32'h0, w, rw, rd, rdat);
        check("byte_commit_40", rdat, 32'h1122_AB44);

        // Halfword lanes at 0x46 and 0x44
        xfer(0, 1'b1, 3'b010, 32'h44, 32'h0000_0000, w, rw, rd, rdat);
        xfer(0, 1'b1, 3'b001, 32'h46, 32'hCAFE_0000, w, rw, rd, rdat);
        xfer(0, 1'b0, 3'b010, 32'h44, 32'h0, w, rw, rd, rdat);
        check("half_hi_44", rdat, 32'hCAFE_0000);
        xfer(0, 1'b1, 3'b001, 32'h44, 32'h1111_BEEF, w, rw, rd, rdat);
        xfer(0, 1'b0, 3'b010, 32'h44, 32'h0, w, rw, rd, rdat);
        check("half_lo_44", rdat, 32'hCAFE_BEEF);

        // Address phase with HREADY_IN low is ignored
        xfer(0, 1'b1, 3'b010, 32'h08, 32'hA5A5_A5A5, w, rw, rd, rdat);
        t_hin_en[0] = 1'b0;
        t_sel[0]    = 1'b1;
        t_trans[0]  = 2'b10;
        t_write[0]  = 1'b1;
        t_size[0]   = 3'b010;
        t_addr[0]   = 32'h08;
        @(negedge HCLK);
        check("hin0_ready", 32'(o_ready[0]), 32'd1);
        check("hin0_resp",  32'(o_resp[0]),  32'd0);
        t_hin_en[0] = 1'b1;
        t_sel[0]    = 1'b0;
        t_trans[0]  = 2'b00;
        t_wdata[0]  = 32'hFFFF_FFFF;
        @(negedge HCLK);
        check("hin0_idle_ready", 32'(o_ready[0]), 32'd1);
        check("hin0_idle_resp",  32'(o_resp[0]),  32'd0);
        xfer(0, 1'b0, 3'b010, 32'h08, 32'h0, w, rw, rd, rdat);
        check("hin0_mem_kept", rdat, 32'hA5A5_A5A5);

        // Out-of-range handling
        xfer(0, 1'b1, 3'b010, 32'h000, 32'h0BAD_F00D, w, rw, rd, rdat);
`ifdef AHB_SRAM_ERR_EN
        xfer(0, 1'b0, 3'b010, 32'h400, 32'h0, w, rw, rd, rdat);
        check("err_rd_waits",  32'(w),  32'd1);
        check("err_rd_resp1",  32'(rw), 32'd1);
        check("err_rd_resp2",  32'(rd), 32'd1);
        check("err_rd_hold",   rdat,    32'hA5A5_A5A5);
        xfer(0, 1'b1, 3'b010, 32'h402, 32'hFFFF_FFFF, w, rw, rd, rdat);
        check("err_wr_waits",  32'(w),  32'd1);
        check("err_wr_resp2",  32'(rd), 32'd1);
        xfer(0, 1'b0, 3'b010, 32'h000, 32'h0, w, rw, rd, rdat);
        check("err_wr_nomem",  rdat,    32'h0BAD_F00D);
        check("err_after_ok",  32'(rd), 32'd0);
        xfer(1, 1'b0, 3'b001, 32'h11, 32'h0, w, rw, rd, rdat);
        check("err_ws2_waits", 32'(w),  32'd1);
        check("err_ws2_resp",  32'(rd), 32'd1);
`else
        xfer(0, 1'b0, 3'b010, 32'h400, 32'h0, w, rw, rd, rdat);
        check("wrap_rd_waits", 32'(w),  32'd0);
        check("wrap_rd_resp",  32'(rd), 32'd0);
        check("wrap_rd_data",  rdat,    32'h0BAD_F00D);
        xfer(0, 1'b0, 3'b010, 32'h402, 32'h0, w, rw, rd, rdat);
        check("misalign_word", rdat,    32'h0BAD_F00D);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Parametrised AHB-Lite SRAM slave that succeeds the fixed single-latency memory slave on the system bus. It adds configurable depth and wait states, true address/data-phase pipelining with HREADY input qualification, and byte-lane writes derived from HSIZE/HADDR. It also adds write-to-read forwarding for back-to-back transfers and an optional two-cycle ERROR response. It sits behind the bus decoder and serves as instruction/data RAM for the core.

## Interface
- MEM_BYTES, 1024: memory size in bytes; power of two, ≥ 8; word count = MEM_BYTES/4.
- WAIT_STATES, 0: HREADY-low cycles inserted in every OKAY data phase (0..15).
- HCLK  input  1  bus clock; all state changes on rising edge.
- HRESET  input  1  synchronous, active-high reset.
- HSEL  input  1  slave select from decoder.
- HADDR  input  32  byte address (address phase).
- HTRANS  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  input  1  1 = write.
- HSIZE  input  3  000 byte, 001 halfword, 010 word; others are treated as word.
- HWDATA  input  32  write data (data phase).
- HREADY_IN  input  1  bus-level HREADY; the address phase is valid only when this is 1.
- HRDATA  output  32  read data, full word, byte lanes unshifted.
- HREADY  output  1  data phase completes when 1.
- HRESP  output  2  00 OKAY, 01 ERROR.

## Operation
- Accept: HSEL & HREADY_IN & HTRANS[1] at a rising edge. Latch addr, write, and byte-enable mask BE[3:0]:
  - byte: 1 << HADDR[1:0]
  - half: 0011 or 1100 by HADDR[1]
  - word: 1111
- IDLE/BUSY, or unselected: no access; the next data phase is OKAY with zero wait.
- Word index = addr[log2(MEM_BYTES)-1:2]. Without ERR_EN, the upper address bits are ignored, so addresses wrap modulo MEM_BYTES.
- FSM states:
  - IDLE: HREADY=1, HRESP=00.
  - WAIT: HREADY=0; counter counts WAIT_STATES down to 1, then goes to DONE.
  - DONE: HREADY=1. If WAIT_STATES=0, an accepted transfer goes directly to DONE.
  - ERR1: HREADY=0, HRESP=01.
  - ERR2: HREADY=1, HRESP=01.
- Leaving DONE or ERR2: a new transfer accepted in the same cycle re-enters WAIT, DONE, or ERR1; otherwise the FSM goes to IDLE.
- Write commit: at the edge ending DONE, mem[idx] lanes with BE=1 take the matching HWDATA lanes. Other lanes are unchanged.
- Read: HRDATA is registered and valid throughout DONE. It holds its last value elsewhere.
- Forwarding: if a read is accepted on the same edge a write commits to the same word index, HRDATA returns merged data:
  - lanes with BE=1 take the written HWDATA lanes;
  - all other lanes take the old memory contents.

## Timing
- Reset values: HREADY=1, HRESP=00, HRDATA=0, FSM=IDLE, counter=0, pending write discarded. Memory contents are not cleared.
- Reset mid-transfer: the next cycle is IDLE with HREADY=1; no write occurs.
- Read latency: address edge, then WAIT_STATES cycles with HREADY=0, then one DONE cycle with HRDATA valid.
- Pipelining: back-to-back NONSEQ/SEQ at WAIT_STATES=0 sustains one transfer per cycle.
- An address phase with HREADY_IN=0 is ignored, even when HSEL=1.
- ERROR: always exactly 2 cycles (ERR1 then ERR2), independent of WAIT_STATES. A transfer accepted during ERR2 is processed normally.
- Simultaneous reset and accept: reset wins.

## Configuration
- AHB_SRAM_ERR_EN defined:
  - Out-of-range (addr ≥ MEM_BYTES), misaligned (half with addr[0]=1, word with addr[1:0]≠00), and HSIZE>010 transfers take the ERR1→ERR2 path.
  - No memory write occurs on these transfers, and HRDATA is unchanged.
- Not defined:
  - Every transfer is OKAY and addresses wrap.
  - Misaligned low bits are forced: half uses addr[1] only; word ignores addr[1:0].
  - The ERR states are not generated.

## Test plan
- Reset: assert HRESET 2 cycles mid-WAIT -> HREADY=1, HRESP=00, HRDATA=0 next cycle; the pending write to 0x10 does not appear in memory.
- WAIT_STATES=2, word write 0xDEADBEEF @0x20, then read @0x20 -> each data phase shows 2 cycles HREADY=0 then 1; read returns 0xDEADBEEF.
- WAIT_STATES=0, back-to-back byte write 0xAB @0x41 then word read @0x40, with the prior word 0x11223344 -> HRDATA=0x1122AB44 in the cycle after the read address phase (forwarding).
- Halfword write 0xCAFE @0x46, then word read @0x44 with prior word 0 -> 0xCAFE0000.
- With AHB_SRAM_ERR_EN, MEM_BYTES=1024: word read @0x400 -> HREADY 0 then 1, HRESP=01 both cycles; word write @0x402 -> ERROR and memory unchanged. Without the macro, a read @0x400 returns mem[0].
- HREADY_IN=0 with HSEL=1, NONSEQ write @0x08 -> ignored; a following IDLE cycle stays OKAY, and mem[2] is unchanged.
